// File: rtl/audio_pkg.sv
// audio_pkg: shared sample type, saturation limits and drain FSM states for the audio output path
package audio_pkg;
   localparam int SAMPLE_W = 24;
   typedef logic signed [SAMPLE_W-1:0] sample_t;
   localparam sample_t SAMPLE_MAX = 24'h7FFFFF;
   localparam sample_t SAMPLE_MIN = 24'h800000;
   typedef enum logic {IDLE, WRITE} drain_state_t;
endpackage

// File: rtl/sample_fifo.sv
// sample_fifo: single-clock FIFO of sample_t with registered storage and count
// Ports: clk, reset (sync, active-high); i_push/i_data write the tail; i_pop advances the head;
//        o_head is the registered head entry; o_count/o_full/o_empty derive from the registered count.
module sample_fifo
   import audio_pkg::*;
#(
   parameter int DEPTH_LOG2 = 3
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                i_push,
   input  sample_t             i_data,
   input  logic                i_pop,
   output sample_t             o_head,
   output logic [DEPTH_LOG2:0] o_count,
   output logic                o_full,
   output logic                o_empty
);
   localparam int DEPTH = 1 << DEPTH_LOG2;
   sample_t                 r_mem [DEPTH];
   logic [DEPTH_LOG2-1:0]   r_wr_ptr;
   logic [DEPTH_LOG2-1:0]   r_rd_ptr;
   logic [DEPTH_LOG2:0]     r_count;
   logic                    w_push;
   logic                    w_pop;
   assign o_full  = r_count == (DEPTH_LOG2+1)'(DEPTH);
   assign o_empty = r_count == '0;
   assign w_push  = i_push & ~o_full;
   assign w_pop   = i_pop & ~o_empty;
   assign o_head  = r_mem[r_rd_ptr];
   assign o_count = r_count;
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= i_data;
   end
   // Pointers wrap naturally at 2^DEPTH_LOG2; count needs the extra bit to represent full.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
         r_count <= r_count + (DEPTH_LOG2+1)'(w_push) - (DEPTH_LOG2+1)'(w_pop);
      end
   end
endmodule

// File: rtl/audio_out_writer.sv
// audio_out_writer: buffers mono samples and drains them to the CODEC on both channels
// Ports: clk, reset (sync, active-high); i_in_valid/i_in_data/o_in_ready sample input handshake;
//        i_write_ready/o_write CODEC write handshake; o_writedata_left/right output sample (identical);
//        o_level buffered sample count (excludes the output registers); o_overflow sticky drop flag.
// Optional feature: define OUT_GAIN_EN to scale each sample by 2^GAIN_SHIFT with 24-bit saturation.
module audio_out_writer
   import audio_pkg::*;
#(
   parameter int DEPTH_LOG2 = 3,
   parameter int GAIN_SHIFT = 2
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                i_in_valid,
   input  sample_t             i_in_data,
   output logic                o_in_ready,
   input  logic                i_write_ready,
   output logic                o_write,
   output sample_t             o_writedata_left,
   output sample_t             o_writedata_right,
   output logic [DEPTH_LOG2:0] o_level,
   output logic                o_overflow
);
   drain_state_t r_state;
   drain_state_t w_state_nxt;
   sample_t      r_data;
   sample_t      w_head;
   sample_t      w_gain;
   logic         w_full;
   logic         w_empty;
   logic         w_push;
   logic         w_pop;
   logic         r_overflow;
   // Full comes from the registered count, so a same-cycle pop never frees room for a push.
   assign o_in_ready = ~w_full & ~reset;
   assign w_push     = i_in_valid & o_in_ready;
   sample_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .i_push  (w_push),
      .i_data  (i_in_data),
      .i_pop   (w_pop),
      .o_head  (w_head),
      .o_count (o_level),
      .o_full  (w_full),
      .o_empty (w_empty)
   );
`ifdef OUT_GAIN_EN
   localparam int WW = SAMPLE_W + GAIN_SHIFT;
   logic signed [WW-1:0] w_wide;
   logic [GAIN_SHIFT:0]  w_top;
   assign w_wide = WW'(w_head) <<< GAIN_SHIFT;
   // The result fits in 24 bits only when every bit above the new sign bit matches it.
   assign w_top  = w_wide[WW-1:SAMPLE_W-1];
   assign w_gain = (&w_top | ~|w_top) ? sample_t'(w_wide[SAMPLE_W-1:0])
                                      : (w_wide[WW-1] ? SAMPLE_MIN : SAMPLE_MAX);
`else
   assign w_gain = w_head;
`endif
   // Pop whenever the output registers are empty (IDLE) or being handed to the CODEC this edge.
   always_comb begin
      w_pop       = ~w_empty & ((r_state == IDLE) | i_write_ready);
      w_state_nxt = (r_state == IDLE) ? (w_empty ? IDLE : WRITE)
                                      : ((i_write_ready & w_empty) ? IDLE : WRITE);
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= IDLE;
         r_data     <= '0;
         r_overflow <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (w_pop) r_data <= w_gain;
         if (i_in_valid & w_full) r_overflow <= 1'b1;
      end
   end
   assign o_write           = r_state == WRITE;
   assign o_writedata_left  = r_data;
   assign o_writedata_right = r_data;
   assign o_overflow        = r_overflow;
endmodule

// File: tb/tb_audio_out_writer.sv
// tb_audio_out_writer: directed self-checking bench for audio_out_writer
module tb_audio_out_writer;
   import audio_pkg::*;
   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       in_valid = 1'b0;
   sample_t    in_data = '0;
   logic       write_ready = 1'b0;
   logic       in_ready;
   logic       write;
   sample_t    wd_left;
   sample_t    wd_right;
   logic [3:0] level;
   logic       overflow;
   int         errors = 0;
   int         checks = 0;
   audio_out_writer #(.DEPTH_LOG2(3), .GAIN_SHIFT(2)) dut (
      .clk               (clk),
      .reset             (reset),
      .i_in_valid        (in_valid),
      .i_in_data         (in_data),
      .o_in_ready        (in_ready),
      .i_write_ready     (write_ready),
      .o_write           (write),
      .o_writedata_left  (wd_left),
      .o_writedata_right (wd_right),
      .o_level           (level),
      .o_overflow        (overflow)
   );
   always #5 clk = ~clk;
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   task automatic chk_out(input string tag, input logic w, input logic [23:0] d);
      chk({tag, "_write"}, 24'(write), 24'(w));
      chk({tag, "_left"}, wd_left, d);
      chk({tag, "_right"}, wd_right, d);
   endtask
   initial begin
      step();
      step();
      chk("rst_in_ready", 24'(in_ready), 24'd0);
      chk_out("rst", 1'b0, 24'd0);
      chk("rst_level", 24'(level), 24'd0);
      chk("rst_overflow", 24'(overflow), 24'd0);
      reset = 1'b0;
      #1;
      chk("post_rst_in_ready", 24'(in_ready), 24'd1);
      // single sample latency
      write_ready = 1'b1;
      in_valid = 1'b1;
      in_data = 24'd175;
      step();
      in_valid = 1'b0;
      chk("lat_level1", 24'(level), 24'd1);
      chk("lat_write0", 24'(write), 24'd0);
      step();
      chk_out("lat_out", 1'b1, 24'd175);
      chk("lat_level0", 24'(level), 24'd0);
      step();
      chk("lat_drop", 24'(write), 24'd0);
      // hold while CODEC not ready
      write_ready = 1'b0;
      in_valid = 1'b1;
      in_data = 24'd187;
      step();
      in_valid = 1'b0;
      step();
      for (int i = 0; i < 5; i++) begin
         chk_out("hold", 1'b1, 24'd187);
         step();
      end
      write_ready = 1'b1;
      step();
      chk("hold_once", 24'(write), 24'd0);
      chk("hold_level", 24'(level), 24'd0);
      step();
      chk("hold_once2", 24'(write), 24'd0);
      // fill, overflow, ordered drain
      write_ready = 1'b0;
      in_valid = 1'b1;
      for (int k = 1; k <= 9; k++) begin
         in_data = sample_t'(k);
         step();
      end
      in_data = 24'd10;
      chk("fill_level", 24'(level), 24'd8);
      chk("fill_in_ready", 24'(in_ready), 24'd0);
      chk("fill_ovf_pre", 24'(overflow), 24'd0);
      step();
      in_valid = 1'b0;
      chk("fill_ovf", 24'(overflow), 24'd1);
      chk("fill_level_hold", 24'(level), 24'd8);
      write_ready = 1'b1;
      for (int k = 1; k <= 9; k++) begin
         chk_out("drain", 1'b1, 24'(k));
         step();
      end
      chk("drain_end_write", 24'(write), 24'd0);
      chk("drain_end_level", 24'(level), 24'd0);
      chk("drain_ovf_sticky", 24'(overflow), 24'd1);
      // back-to-back throughput
      in_valid = 1'b1;
      in_data = 24'd1;
      step();
      in_data = 24'd2;
      step();
      chk_out("b2b1", 1'b1, 24'd1);
      in_data = 24'd3;
      step();
      in_valid = 1'b0;
      chk_out("b2b2", 1'b1, 24'd2);
      step();
      chk_out("b2b3", 1'b1, 24'd3);
      step();
      chk("b2b_end", 24'(write), 24'd0);
      // gain / pass-through vectors
      in_valid = 1'b1;
      in_data = 24'h300000;
      step();
      in_valid = 1'b0;
      step();
`ifdef OUT_GAIN_EN
      chk_out("gain_pos_sat", 1'b1, 24'h7FFFFF);
`else
      chk_out("pass_pos", 1'b1, 24'h300000);
`endif
      step();
      in_valid = 1'b1;
      in_data = 24'hC00000;
      step();
      in_valid = 1'b0;
      step();
`ifdef OUT_GAIN_EN
      chk_out("gain_neg_sat", 1'b1, 24'h800000);
`else
      chk_out("pass_neg", 1'b1, 24'hC00000);
`endif
      step();
      in_valid = 1'b1;
      in_data = 24'hFFFFFB;
      step();
      in_valid = 1'b0;
      step();
`ifdef OUT_GAIN_EN
      chk_out("gain_small", 1'b1, 24'hFFFFEC);
`else
      chk_out("pass_small", 1'b1, 24'hFFFFFB);
`endif
      step();
      chk("gain_end", 24'(write), 24'd0);
      // reset mid-operation
      write_ready = 1'b0;
      in_valid = 1'b1;
      for (int k = 7; k <= 10; k++) begin
         in_data = sample_t'(k);
         step();
      end
      in_valid = 1'b0;
      chk_out("mid_pre", 1'b1, 24'd7);
      chk("mid_pre_level", 24'(level), 24'd3);
      reset = 1'b1;
      step();
      chk_out("mid_rst", 1'b0, 24'd0);
      chk("mid_rst_level", 24'(level), 24'd0);
      chk("mid_rst_ovf", 24'(overflow), 24'd0);
      chk("mid_rst_in_ready", 24'(in_ready), 24'd0);
      reset = 1'b0;
      write_ready = 1'b1;
      in_valid = 1'b1;
      in_data = 24'd42;
      step();
      in_valid = 1'b0;
      step();
      chk_out("post_rst", 1'b1, 24'd42);
      step();
      for (int i = 0; i < 3; i++) begin
         chk("post_rst_idle", 24'(write), 24'd0);
         step();
      end
      chk("post_rst_level", 24'(level), 24'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
